rle_dec: RTL and testbench
==========================

RLE_DEC -- requirements
Module: rle_dec

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: core_clk  in  1  clock, all logic rising-edge; core_rst  in  1  asynchronous active-high reset.
REQ-002 dec_en  in  1  decoder enable; low synchronously flushes all state.
REQ-003 rle_data  in  16  encoded word; bit15=0: sample in [14:0]; bit15=1: N=[14:0] extra repeats of last sample.
REQ-004 rle_valid  in  1  rle_data valid.
REQ-005 rle_ready  out  1  word accepted when rle_valid & rle_ready at core_clk edge.
REQ-006 dec_data  out  15  decoded sample.
REQ-007 dec_valid  out  1  dec_data valid.
REQ-008 dec_ready  in  1  sink accepts; transfer = dec_valid & dec_ready.
REQ-009 dec_sample_cnt  out  25  count of transferred decoded samples.
REQ-010 dec_err  out  1  sticky protocol error (only with RLE_DEC_ERR_EN; else tied 0).

Function
REQ-011 States SHALL be: IDLE (output reg empty), EMIT (one sample presented), REPEAT (last sample presented, rem>0 copies left incl. current).
REQ-012 Sample word accepted SHALL load dec_data and last_reg with [14:0], set dec_valid next cycle (latency 1), go to EMIT.
REQ-013 Count word with N>0 SHALL load rem=N, go to REPEAT, present last_reg, keep dec_valid high.
REQ-014 Count word with N=0 SHALL be consumed with no output and no state change.
REQ-015 In REPEAT each transfer SHALL decrement rem; transfer at rem=1 exits to EMIT if a word is accepted same cycle, else IDLE.
REQ-016 rle_ready SHALL be (state!=REPEAT | (rem==1 & dec_ready)) & (~dec_valid | dec_ready) & dec_en, combinational, sustaining 1 word/cycle for sample streams.
REQ-017 dec_valid SHALL hold with dec_data stable until transfer (no drop under back-pressure).
REQ-018 In EMIT, a transfer with no accepted word SHALL go IDLE and clear dec_valid.
REQ-019 0xFFFF (N=32767) SHALL decode as 32767 repeats; consecutive count words SHALL accumulate sequentially.
REQ-020 rem SHALL be 15 bits, never underflow; N handling unsigned.
REQ-021 dec_sample_cnt SHALL increment by 1 per transfer, wrap 0x1FFFFFF->0.
REQ-022 Count word before any sample since reset/flush SHALL be a protocol error (see REQ-027/028).

Reset
REQ-023 On core_rst: state=IDLE, dec_valid=0, dec_data=0, last_reg=0, rem=0, dec_sample_cnt=0, dec_err=0, rle_ready=0.
REQ-024 dec_en low SHALL have the same effect synchronously at next edge, including mid-REPEAT (remaining repeats discarded).
REQ-025 Reset asserted mid-transfer SHALL discard the in-flight word; no output until a new sample word.

Configuration
REQ-026 Macro RLE_DEC_ERR_EN SHALL select error detection.
REQ-027 Defined: a count word with no prior sample SHALL be dropped (no output) and set dec_err until reset or dec_en low.
REQ-028 Undefined: such a count word SHALL repeat last_reg (0) N times; dec_err constant 0.

Structure
REQ-029 Shared package SHALL hold state enum (IDLE/EMIT/REPEAT), RLE_CNT_FLAG bit index 15, RLE_CNT_MAX 15'h7FFF, sample width 15, sample-count width 25.
REQ-030 Single module, no sub-module; optional rle_dec_cnt counter for dec_sample_cnt only.

Verification
REQ-031 Words 0x0005,0x8003, dec_ready=1 -> dec_data 0x0005 x4 on consecutive cycles, dec_sample_cnt=4.
REQ-032 0x1234,0x1235,0x1236 back-to-back, dec_ready=1 -> 3 outputs, rle_ready constantly 1.
REQ-033 0x0001,0xFFFF,0x8002 -> 0x0001 x32770, no gaps with dec_ready=1.
REQ-034 0x0007,0x8004, dec_ready toggling 1010... -> 0x0007 x5, data stable while stalled.
REQ-035 0x8005 after reset: with RLE_DEC_ERR_EN -> no output, dec_err=1; without -> 0x0000 x5.
REQ-036 dec_en low mid-REPEAT (rem=10) -> dec_valid=0 next cycle, cnt=0, no residual output after re-enable.

Source files
------------

// File: rtl/rle_dec_pkg.sv
`default_nettype none
// ============================================================
// rle_dec_pkg : shared types and constants for the RLE decoder
// Rev 1.0
// ============================================================
package rle_dec_pkg;

  localparam int          SAMPLE_W     = 15;
  localparam int          CNT_W        = 25;
  localparam int          RLE_CNT_FLAG = 15;
  localparam logic [14:0] RLE_CNT_MAX  = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    REPEAT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rle_dec_cnt.sv
`default_nettype none
// ============================================================
// rle_dec_cnt : wrapping transfer counter with synchronous clear
// Rev 1.0
// ============================================================
module rle_dec_cnt
  import rle_dec_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/rle_dec.sv
`default_nettype none
// ============================================================
// rle_dec : run-length decoder, sample/count words in, samples out
// Rev 1.0 -- optional error detection via RLE_DEC_ERR_EN
// ============================================================
module rle_dec
  import rle_dec_pkg::*;
(
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic                dec_en,
  input  logic [SAMPLE_W:0]   rle_data,
  input  logic                rle_valid,
  output logic                rle_ready,
  output logic [SAMPLE_W-1:0] dec_data,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [CNT_W-1:0]    dec_sample_cnt,
  output logic                dec_err
);

  state_t              r_state, w_state_nxt;
  logic [SAMPLE_W-1:0] r_data, w_data_nxt;
  logic [SAMPLE_W-1:0] r_last, w_last_nxt;
  logic [SAMPLE_W-1:0] r_rem, w_rem_nxt;
  logic                r_valid, w_valid_nxt;
  logic                w_is_cnt, w_xfer, w_ready, w_accept, w_orphan;
  logic [SAMPLE_W-1:0] w_n;

  assign w_is_cnt = rle_data[RLE_CNT_FLAG];
  assign w_n      = rle_data[SAMPLE_W-1:0] & RLE_CNT_MAX;
  assign w_xfer   = r_valid & dec_ready;

  // A new word may only land when the presented sample is leaving this cycle.
  assign w_ready  = ((r_state != REPEAT) | ((r_rem == 15'd1) & dec_ready))
                  & (~r_valid | dec_ready) & dec_en & ~core_rst;
  assign w_accept = rle_valid & w_ready;

`ifdef RLE_DEC_ERR_EN
  logic r_seen, r_err;

  assign w_orphan = w_is_cnt & ~r_seen;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_seen <= 1'b0;
      r_err  <= 1'b0;
    end else if (!dec_en) begin
      r_seen <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      if (!w_is_cnt) r_seen <= 1'b1;
      if (w_orphan)  r_err  <= 1'b1;
    end
  end

  assign dec_err = r_err;
`else
  assign w_orphan = 1'b0;
  assign dec_err  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_rem_nxt   = r_rem;
    w_valid_nxt = r_valid;

    if (w_xfer) begin
      case (r_state)
        EMIT: begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
        REPEAT: begin
          if (r_rem <= 15'd1) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_rem_nxt   = '0;
          end else begin
            w_rem_nxt   = r_rem - 15'd1;
          end
        end
        default: ;
      endcase
    end

    // Accepted words override the drain outcome; a zero count is a no-op.
    if (w_accept && !w_orphan) begin
      if (!w_is_cnt) begin
        w_state_nxt = EMIT;
        w_data_nxt  = rle_data[SAMPLE_W-1:0];
        w_last_nxt  = rle_data[SAMPLE_W-1:0];
        w_valid_nxt = 1'b1;
      end else if (w_n != '0) begin
        w_state_nxt = REPEAT;
        w_rem_nxt   = w_n;
        w_data_nxt  = r_last;
        w_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_last  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
    end else if (!dec_en) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_last  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_rem   <= w_rem_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  rle_dec_cnt #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk (core_clk),
    .rst (core_rst),
    .clr (~dec_en),
    .inc (w_xfer),
    .cnt (dec_sample_cnt)
  );

  assign rle_ready = w_ready;
  assign dec_data  = r_data;
  assign dec_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rle_dec.sv
`default_nettype none
// ============================================================
// tb_rle_dec : scoreboard bench for rle_dec with a queue-based model
// Rev 1.0
// ============================================================
module tb_rle_dec;

  logic        core_clk;
  logic        core_rst;
  logic        dec_en;
  logic [15:0] rle_data;
  logic        rle_valid;
  logic        rle_ready;
  logic [14:0] dec_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [24:0] dec_sample_cnt;
  logic        dec_err;

  rle_dec dut (
    .core_clk       (core_clk),
    .core_rst       (core_rst),
    .dec_en         (dec_en),
    .rle_data       (rle_data),
    .rle_valid      (rle_valid),
    .rle_ready      (rle_ready),
    .dec_data       (dec_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_sample_cnt (dec_sample_cnt),
    .dec_err        (dec_err)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: expected output stream built from the word rules
  logic [14:0] exp_q[$];
  logic [14:0] m_last = '0;
  bit          m_seen = 1'b0;
  bit          m_err  = 1'b0;
  int          n_xfer = 0;

  bit          strict  = 1'b0;
  bit          started = 1'b0;
  int          rdy_mode = 0;  // 0: always, 1: toggle, 2: random, 3: hold
  bit          prev_stall = 1'b0;
  logic [14:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_accept(input logic [15:0] w);
    if (!w[15]) begin
      m_last = w[14:0];
      m_seen = 1'b1;
      exp_q.push_back(w[14:0]);
    end else begin
`ifdef RLE_DEC_ERR_EN
      if (!m_seen) begin
        m_err = 1'b1;
        return;
      end
`endif
      for (int i = 0; i < int'(w[14:0]); i++) exp_q.push_back(m_last);
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    m_last = '0;
    m_seen = 1'b0;
    m_err  = 1'b0;
    n_xfer = 0;
  endtask

  initial begin
    dec_ready = 1'b0;
    forever begin
      @(posedge core_clk);
      #1;
      case (rdy_mode)
        0: dec_ready = 1'b1;
        1: dec_ready = ~dec_ready;
        2: dec_ready = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks hold-under-stall
  always @(negedge core_clk) begin
    if (!core_rst && dec_en) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, dec_valid}, 32'd1);
        check("stall_data", {17'd0, dec_data}, {17'd0, prev_data});
      end
      if (strict && started && exp_q.size() > 0)
        check("no_gap", {31'd0, dec_valid}, 32'd1);
      if (dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {17'd0, dec_data}, 32'hFFFF_FFFF);
        end else begin
          check("dec_data", {17'd0, dec_data}, {17'd0, exp_q.pop_front()});
        end
        check("sample_cnt", {7'd0, dec_sample_cnt}, n_xfer);
        n_xfer++;
        if (strict) started = 1'b1;
      end
      prev_stall = dec_valid & ~dec_ready;
      prev_data  = dec_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] w, input bit must_take, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      rle_valid = 1'b0;
      @(posedge core_clk);
      #1;
    end
    rle_valid = 1'b1;
    rle_data  = w;
    waited    = 0;
    forever begin
      @(negedge core_clk);
      if (rle_ready) break;
      waited++;
      if (waited > 40000) break;
    end
    if (waited > 40000) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (must_take) check("ready_immediate", waited, 0);
      model_accept(w);
    end
    @(posedge core_clk);
    #1;
    rle_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() > 0 || dec_valid) && cyc < 40000) begin
      @(posedge core_clk);
      #1;
      cyc++;
    end
    check("drain_timeout", {31'd0, (cyc >= 40000)}, 32'd0);
    strict  = 1'b0;
    started = 1'b0;
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, rle_ready}, 32'd0);
    check("rst_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_data", {17'd0, dec_data}, 32'd0);
    check("rst_cnt", {7'd0, dec_sample_cnt}, 32'd0);
    check("rst_err", {31'd0, dec_err}, 32'd0);
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    model_flush();
  endtask

  initial begin
    core_rst  = 1'b1;
    dec_en    = 1'b1;
    rle_valid = 1'b0;
    rle_data  = '0;
    repeat (2) @(posedge core_clk);
    #1;
    do_reset();

    // Sample plus count word
    rdy_mode = 0;
    @(posedge core_clk); #1;
    strict = 1'b1;
    send(16'h0005, 1'b1, 0);
    send(16'h8003, 1'b1, 0);
    drain();
    check("cnt_after_4", {7'd0, dec_sample_cnt}, 32'd4);

    // Back-to-back samples at full rate
    strict = 1'b1;
    send(16'h1234, 1'b1, 0);
    send(16'h1235, 1'b1, 0);
    send(16'h1236, 1'b1, 0);
    drain();
    check("cnt_after_7", {7'd0, dec_sample_cnt}, 32'd7);

    // Maximum count followed by a chained count word
    strict = 1'b1;
    send(16'h0001, 1'b1, 0);
    send(16'hFFFF, 1'b1, 0);
    send(16'h8002, 1'b0, 0);
    drain();
    check("cnt_after_max", {7'd0, dec_sample_cnt}, 32'd32777);

    // Toggling back-pressure
    rdy_mode = 1;
    send(16'h0007, 1'b0, 0);
    send(16'h8004, 1'b0, 0);
    drain();
    check("cnt_after_toggle", {7'd0, dec_sample_cnt}, 32'd32782);

    // Count word with no prior sample
    rdy_mode = 0;
    do_reset();
    send(16'h8005, 1'b1, 0);
`ifdef RLE_DEC_ERR_EN
    check("orphan_err", {31'd0, dec_err}, 32'd1);
`else
    check("orphan_err", {31'd0, dec_err}, 32'd0);
`endif
    drain();
    check("orphan_err_model", {31'd0, dec_err}, {31'd0, m_err});

    // Flush mid-REPEAT with ten repeats outstanding
    do_reset();
    send(16'h0009, 1'b1, 0);
    send(16'h8014, 1'b1, 0);
    for (int k = 0; k < 100; k++) begin
      if (n_xfer == 11) break;
      @(posedge core_clk);
      #2;
    end
    check("pre_flush_cnt", {7'd0, dec_sample_cnt}, 32'd11);
    rdy_mode  = 3;
    dec_ready = 1'b0;
    dec_en    = 1'b0;
    #1;
    check("flush_ready", {31'd0, rle_ready}, 32'd0);
    @(negedge core_clk);
    @(negedge core_clk);
    check("flush_valid", {31'd0, dec_valid}, 32'd0);
    check("flush_cnt", {7'd0, dec_sample_cnt}, 32'd0);
    model_flush();
    @(posedge core_clk); #1;
    dec_en   = 1'b1;
    rdy_mode = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge core_clk);
      check("flush_residual", {31'd0, dec_valid}, 32'd0);
    end
    @(posedge core_clk); #1;
    send(16'h0042, 1'b1, 0);
    drain();
    check("post_flush_cnt", {7'd0, dec_sample_cnt}, 32'd1);

    // Asynchronous reset with a word in flight
    rle_valid = 1'b1;
    rle_data  = 16'h0033;
    #3;
    core_rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, rle_ready}, 32'd0);
    @(posedge core_clk); #1;
    core_rst  = 1'b0;
    rle_valid = 1'b0;
    model_flush();
    for (int k = 0; k < 4; k++) begin
      @(negedge core_clk);
      check("midrst_no_out", {31'd0, dec_valid}, 32'd0);
    end
    @(posedge core_clk); #1;

    // Randomized mix of samples and short counts under random stalls
    rdy_mode = 2;
    for (int k = 0; k < 250; k++) begin
      logic [15:0] w;
      if ($urandom_range(0, 9) < 7) w = {1'b0, 15'($urandom)};
      else                          w = {1'b1, 15'($urandom_range(0, 6))};
      send(w, 1'b0, $urandom_range(0, 2));
    end
    drain();
    check("rand_err", {31'd0, dec_err}, {31'd0, m_err});
    check("rand_cnt", {7'd0, dec_sample_cnt}, n_xfer);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
